// File: rtl/xpmwrap_distram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : xpmwrap_distram_fifo_ctrl
//  Purpose  : Stream FIFO controller around a 2-cycle-latency dual-port
//             distributed RAM, with a 4-entry first-word-fall-through buffer.
//  Revision : 1.0
// ============================================================================
module xpmwrap_distram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_wea,
    output logic                  ram_ena,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] c_full_level = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ptr_inc    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [2:0]          c_ob_depth   = 3'd4;

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [1:0]            r_rd_vld;
    logic [DATA_WIDTH-1:0] r_ob_mem [4];
    logic [1:0]            r_ob_wp;
    logic [1:0]            r_ob_rp;
    logic [2:0]            r_ob_cnt;

    logic                  w_full;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_cap;
    logic                  w_pop;
    logic [2:0]            w_credit_used;

    assign level    = r_wr_ptr - r_rd_ptr;
    assign w_full   = (level == c_full_level);
    assign s_tready = !w_full && !rsta;
    assign w_wr     = s_tvalid && s_tready;

    assign ram_wea    = w_wr;
    assign ram_ena    = w_wr;
    assign ram_addra  = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_dina   = s_tdata;
    assign ram_regceb = 1'b1;

    // Words in flight are counted against buffer space so a capture can never overflow it.
    assign w_credit_used = {2'b00, r_rd_vld[0]} + {2'b00, r_rd_vld[1]} + r_ob_cnt;
    assign w_rd          = (level != '0) && (w_credit_used < c_ob_depth) && !rsta;
    assign ram_enb       = w_rd;
    assign ram_addrb     = r_rd_ptr[ADDR_WIDTH-1:0];

    assign w_cap    = r_rd_vld[1];
    assign m_tvalid = (r_ob_cnt != 3'd0);
    assign m_tdata  = r_ob_mem[r_ob_rp];
    assign w_pop    = m_tvalid && m_tready;

    assign empty = (level == '0) && (r_rd_vld == 2'b00) && (r_ob_cnt == 3'd0);

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rd_vld <= 2'b00;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_inc;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_inc;
            end
            r_rd_vld <= {r_rd_vld[0], w_rd};
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_ob_wp  <= 2'd0;
            r_ob_rp  <= 2'd0;
            r_ob_cnt <= 3'd0;
        end else begin
            if (w_cap) begin
                r_ob_wp <= r_ob_wp + 2'd1;
            end
            if (w_pop) begin
                r_ob_rp <= r_ob_rp + 2'd1;
            end
            case ({w_cap, w_pop})
                2'b10:   r_ob_cnt <= r_ob_cnt + 3'd1;
                2'b01:   r_ob_cnt <= r_ob_cnt - 3'd1;
                default: r_ob_cnt <= r_ob_cnt;
            endcase
        end
    end

    // Buffer storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clka) begin
        if (w_cap) begin
            r_ob_mem[r_ob_wp] <= ram_doutb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xpmwrap_distram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xpmwrap_distram_fifo_ctrl
//  Purpose  : Scoreboard bench for xpmwrap_distram_fifo_ctrl with a RAM model.
//  Revision : 1.0
// ============================================================================
module tb_xpmwrap_distram_fifo_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clka = 1'b0;
    logic          rsta;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic          ram_wea;
    logic          ram_ena;
    logic [AW-1:0] ram_addrb;
    logic          ram_enb;
    logic          ram_regceb;
    logic [DW-1:0] ram_doutb;
    logic [AW:0]   level;
    logic          empty;

    always #5 clka = ~clka;

    xpmwrap_distram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clka(clka), .rsta(rsta),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_ena(ram_ena),
        .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb),
        .ram_doutb(ram_doutb), .level(level), .empty(empty)
    );

    // Dual-port RAM, old-data read, read latency 2 (enb stage then regceb stage).
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q1;
    logic [DW-1:0] ram_q2;
    always @(posedge clka) begin
        if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
        if (ram_enb) ram_q1 <= ram_mem[ram_addrb];
        if (ram_regceb) ram_q2 <= ram_q1;
    end
    assign ram_doutb = ram_q2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    logic lvl_chk = 1'b0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: record accepted input words, compare every popped head word.
    always @(negedge clka) begin
        if (rsta) begin
            exp_q.delete();
        end else begin
            if (s_tvalid && s_tready) exp_q.push_back(s_tdata);
            if (m_tvalid && m_tready) begin
                n_pop++;
                if (exp_q.size() == 0) check("unexpected_output", {32'd0, m_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("m_tdata", {32'd0, m_tdata}, {32'd0, exp_q.pop_front()});
            end
            if (lvl_chk) check("level_le_64", {63'd0, (level <= 7'd64)}, 64'd1);
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic drain(input string name, input int base, input int expect_pops);
        int c;
        c = 0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        while (!(exp_q.size() == 0 && empty === 1'b1) && c < 1000) begin
            step();
            c++;
        end
        check({name, "_drain_in_time"}, {63'd0, (c < 1000)}, 64'd1);
        check({name, "_pops"}, 64'(n_pop - base), 64'(expect_pops));
        m_tready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;
        rsta = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;

        // Reset held for three checked cycles
        for (int k = 0; k < 3; k++) begin
            @(negedge clka);
            check("rst_s_tready", {63'd0, s_tready}, 64'd0);
            check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
            check("rst_empty", {63'd0, empty}, 64'd1);
            check("rst_level", {57'd0, level}, 64'd0);
            check("rst_ram_enb", {63'd0, ram_enb}, 64'd0);
            step();
        end
        rsta = 1'b0;
        @(negedge clka);
        check("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
        check("post_rst_empty", {63'd0, empty}, 64'd1);
        step();
        repeat (3) step();

        // Single word, 4-cycle first-word latency
        s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF;
        @(negedge clka);
        check("single_wea", {63'd0, ram_wea}, 64'd1);
        check("single_ena", {63'd0, ram_ena}, 64'd1);
        check("single_addra", {58'd0, ram_addra}, 64'd0);
        check("single_dina", {32'd0, ram_dina}, 64'hDEADBEEF);
        check("single_enb_t0", {63'd0, ram_enb}, 64'd0);
        step(); s_tvalid = 1'b0;
        @(negedge clka);
        check("single_enb_t1", {63'd0, ram_enb}, 64'd1);
        check("single_level_t1", {57'd0, level}, 64'd1);
        check("single_addrb_t1", {58'd0, ram_addrb}, 64'd0);
        step();
        @(negedge clka);
        check("single_enb_t2", {63'd0, ram_enb}, 64'd0);
        check("single_empty_t2", {63'd0, empty}, 64'd0);
        step();
        @(negedge clka);
        check("single_mvalid_t3", {63'd0, m_tvalid}, 64'd0);
        step(); m_tready = 1'b1;
        @(negedge clka);
        check("single_mvalid_t4", {63'd0, m_tvalid}, 64'd1);
        step(); m_tready = 1'b0;
        @(negedge clka);
        check("single_mvalid_t5", {63'd0, m_tvalid}, 64'd0);
        check("single_empty_t5", {63'd0, empty}, 64'd1);
        step();

        // Fill to full with the consumer stalled: 64 in RAM + 4 buffered
        base = n_pop; acc = 0;
        for (int c = 0; c < 400 && acc < 68; c++) begin
            s_tvalid = 1'b1; s_tdata = 32'(acc);
            @(negedge clka);
            if (s_tready) acc++;
            step();
        end
        check("fill_accepted", 64'(acc), 64'd68);
        s_tvalid = 1'b1; s_tdata = 32'd68;
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            check("full_s_tready", {63'd0, s_tready}, 64'd0);
            check("full_level", {57'd0, level}, 64'd64);
            check("full_m_tvalid", {63'd0, m_tvalid}, 64'd1);
            step();
        end
        drain("fill", base, 68);

        // Continuous streaming through pointer wrap
        base = n_pop; m_tready = 1'b1;
        for (int k = 0; k < 204; k++) begin
            s_tvalid = (k < 200); s_tdata = 32'hA500_0000 + 32'(k);
            @(negedge clka);
            if (k < 200) check("wrap_s_tready", {63'd0, s_tready}, 64'd1);
            check("wrap_m_tvalid", {63'd0, m_tvalid}, {63'd0, (k >= 4)});
            step();
        end
        drain("wrap", base, 200);

        // Random valid/ready at 50%
        base = n_pop; acc = 0; lvl_chk = 1'b1;
        for (int c = 0; c < 20000 && acc < 2000; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            m_tready = 1'($urandom_range(0, 1));
            @(negedge clka);
            if (s_tvalid && s_tready) acc++;
            step();
        end
        check("rand_accepted", 64'(acc), 64'd2000);
        lvl_chk = 1'b0;
        drain("rand", base, 2000);

        // Reset with 10 words stored and 2 reads in flight
        base = n_pop; m_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            s_tvalid = 1'b1; s_tdata = 32'hC000_0000 + 32'(k);
            step();
        end
        s_tvalid = 1'b0;
        repeat (4) step();
        m_tready = 1'b1;
        @(negedge clka);
        check("mid_mvalid_a", {63'd0, m_tvalid}, 64'd1);
        step();
        @(negedge clka);
        check("mid_enb_a1", {63'd0, ram_enb}, 64'd1);
        step(); m_tready = 1'b0;
        @(negedge clka);
        check("mid_enb_a2", {63'd0, ram_enb}, 64'd1);
        step(); rsta = 1'b1;
        @(negedge clka);
        check("mid_level_pre", {57'd0, level}, 64'd10);
        check("mid_empty_pre", {63'd0, empty}, 64'd0);
        check("mid_rst_s_tready", {63'd0, s_tready}, 64'd0);
        check("mid_rst_enb", {63'd0, ram_enb}, 64'd0);
        step(); rsta = 1'b0;
        @(negedge clka);
        check("mid_post_mvalid", {63'd0, m_tvalid}, 64'd0);
        check("mid_post_level", {57'd0, level}, 64'd0);
        check("mid_post_empty", {63'd0, empty}, 64'd1);
        step();
        s_tvalid = 1'b1; s_tdata = 32'h5;
        @(negedge clka);
        check("mid_w_s_tready", {63'd0, s_tready}, 64'd1);
        check("mid_w_mvalid", {63'd0, m_tvalid}, 64'd0);
        step(); s_tvalid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clka);
            check("mid_wait_mvalid", {63'd0, m_tvalid}, 64'd0);
            step();
        end
        m_tready = 1'b1;
        @(negedge clka);
        check("mid_first_mvalid", {63'd0, m_tvalid}, 64'd1);
        check("mid_first_mdata", {32'd0, m_tdata}, 64'h5);
        step();
        drain("mid", base, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
